// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and widths for the segment feeder slice
package feeder_pkg;

  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic               start;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_PREV,
    FULL
  } state_t;

endpackage

// File: rtl/point_fifo.sv
// rtl/point_fifo.sv - small waypoint FIFO with synchronous clear
module point_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/segment_feeder.sv
// rtl/segment_feeder.sv - turns buffered polyline waypoints into numbered segment pulses
module segment_feeder
  import feeder_pkg::*;
#(
  parameter int COORD_W    = feeder_pkg::COORD_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SEGS   = 61
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pt_val,
  output logic               pt_rdy,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic [COORD_W-1:0] pt_z,
  input  logic               pt_start,
  input  logic               flush,
  output logic               seg_val,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] z1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] z2,
  output logic [7:0]         seg_num,
  output logic               full,
  output logic [7:0]         skipped
);

  localparam int          PW    = 3 * COORD_W + 1;
  localparam logic [7:0]  MAX_C = 8'(MAX_SEGS);

  logic [PW-1:0]      wdata, rdata;
  logic               fifo_empty, fifo_full, push, pop;
  logic [COORD_W-1:0] pop_x, pop_y, pop_z;
  logic               pop_start;

  state_t             state_q;
  logic [COORD_W-1:0] prev_x_q, prev_y_q, prev_z_q;
  logic [COORD_W-1:0] x1_q, y1_q, z1_q, x2_q, y2_q, z2_q;
  logic [7:0]         count_q, seg_num_q, skipped_q;
  logic               seg_val_q, full_q;

  assign pt_rdy = ~fifo_full;
  assign push   = pt_val & pt_rdy & ~flush;
  assign pop    = ~fifo_empty & (state_q != FULL) & ~flush;
  assign wdata  = {pt_start, pt_z, pt_y, pt_x};
  assign {pop_start, pop_z, pop_y, pop_x} = rdata;

  point_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (flush),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prev_x_q  <= '0;
      prev_y_q  <= '0;
      prev_z_q  <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      z1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      z2_q      <= '0;
      count_q   <= '0;
      seg_num_q <= '0;
      skipped_q <= '0;
      seg_val_q <= 1'b0;
      full_q    <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      count_q   <= '0;
      skipped_q <= '0;
      full_q    <= 1'b0;
      seg_val_q <= 1'b0;
    end else begin
      seg_val_q <= 1'b0;
      if (pop) begin
        if (state_q == IDLE || pop_start) begin
          {prev_x_q, prev_y_q, prev_z_q} <= {pop_x, pop_y, pop_z};
          state_q <= HAVE_PREV;
        end else if (pop_z != prev_z_q) begin
          // Travel move: re-anchor on the new layer without drawing.
          {prev_x_q, prev_y_q, prev_z_q} <= {pop_x, pop_y, pop_z};
          if (skipped_q != 8'hFF) skipped_q <= skipped_q + 8'd1;
        end else if (!(pop_x == prev_x_q && pop_y == prev_y_q)) begin
          {x1_q, y1_q, z1_q} <= {prev_x_q, prev_y_q, prev_z_q};
          {x2_q, y2_q, z2_q} <= {pop_x, pop_y, pop_z};
          seg_val_q <= 1'b1;
          seg_num_q <= count_q + 8'd1;
          count_q   <= count_q + 8'd1;
          {prev_x_q, prev_y_q, prev_z_q} <= {pop_x, pop_y, pop_z};
          if (count_q + 8'd1 == MAX_C) begin
            state_q <= FULL;
            full_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign seg_val = seg_val_q;
  assign x1      = x1_q;
  assign y1      = y1_q;
  assign z1      = z1_q;
  assign x2      = x2_q;
  assign y2      = y2_q;
  assign z2      = z2_q;
  assign seg_num = seg_num_q;
  assign full    = full_q;
  assign skipped = skipped_q;

endmodule

// File: doc/segment_feeder.md
# segment_feeder

Stream-to-segment front end for the collision detector. Accepts a stream of 3D toolpath waypoints over a valid/ready handshake, buffers them in a small FIFO, and turns consecutive points of each polyline into line segments. Each segment is presented as a one-cycle pulse with both endpoints, in the `in_val`/`x1..z2` form the collision detector consumes. Also drops travel moves and zero-length moves, numbers each emitted segment to match the detector's `lineID`, and stops at the detector's table capacity.

## Interface
Parameters:
- `COORD_W`, 8: coordinate width.
- `FIFO_DEPTH`, 4: waypoint buffer depth; power of two, ≥2.
- `MAX_SEGS`, 61: segments emitted before the block stops; must be ≤255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pt_val`  in  1  waypoint valid.
- `pt_rdy`  out  1  waypoint accepted when `pt_val & pt_rdy`.
- `pt_x`, `pt_y`, `pt_z`  in  COORD_W  waypoint coordinates, unsigned.
- `pt_start`  in  1  waypoint begins a new polyline.
- `flush`  in  1  synchronous clear of the whole block.
- `seg_val`  out  1  one-cycle segment strobe; drives detector `in_val`.
- `x1`, `y1`, `z1`, `x2`, `y2`, `z2`  out  COORD_W  segment endpoints (start, end).
- `seg_num`  out  8  1-based index of the current segment; equals the detector's `lineID` for that segment.
- `full`  out  1  `MAX_SEGS` segments emitted.
- `skipped`  out  8  count of travel moves (z change), saturating at 255.

## Operation
- FIFO: `pt_rdy` = FIFO not full. A push happens on handshake. A pop happens when the FIFO is non-empty and the state is not FULL. Push and pop may occur in the same cycle. At most one pop per cycle.
- States:
  - IDLE: no previous point is held.
  - HAVE_PREV: a previous point (`prev_x/y/z`) is held.
  - FULL: segment limit reached.
- On each pop, evaluate these rules in priority order:
  1. State is IDLE, or `pt_start`=1: load prev ← point and go to HAVE_PREV. No segment.
  2. `pt_z != prev_z`: this is a travel move. Load prev ← point and increment `skipped` (saturating). No segment.
  3. Point equals prev in x, y and z: discard the point. Prev is unchanged. No segment.
  4. Otherwise: register `x1/y1/z1`←prev, `x2/y2/z2`←point, `seg_val`←1, `seg_num`←count+1. Then set count++ and prev ← point. If count+1 == `MAX_SEGS`, go to FULL and set `full`=1.
- FULL:
  - No further pops.
  - The FIFO keeps accepting points until it is full, then `pt_rdy`=0.
  - The block stays in FULL until `flush` or reset.
- `flush`:
  - Empties the FIFO.
  - Clears count, `skipped` and `full`.
  - State returns to IDLE.
  - Has priority over a push or pop in the same cycle; that cycle's handshake is discarded.
- Between pulses, `x1..z2` and `seg_num` hold their last values. `seg_val` is 0 in every cycle without an emit.
- Arithmetic:
  - All comparisons are unsigned equality on the full COORD_W.
  - count is 8 bits and never exceeds `MAX_SEGS`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `seg_val`, `x1..z2`, `seg_num`, `full` and `skipped` are 0.
  - FIFO is empty and state is IDLE.
  - `pt_rdy`=1.
- Latency: a point accepted at edge N is popped at edge N+1 at the earliest. Its segment's `seg_val` is high in the cycle after edge N+1.
- Throughput: one segment per cycle once the FIFO is primed. `seg_val` may be high on consecutive cycles.
- `pt_rdy` is combinational from the registered FIFO occupancy only. It does not depend on `pt_val`.
- Reset asserted mid-stream: any in-flight `seg_val` is lost; there is no partial segment.

## Structure
- Shared package `feeder_pkg` holds:
  - `COORD_W`;
  - a `point_t` struct {x, y, z, start};
  - the state enum {IDLE, HAVE_PREV, FULL}.
- Sub-module `point_fifo`: parameterised depth and width, with push/pop, `empty`/`full` outputs, and a synchronous clear driven by `flush`. The FSM, prev register, counters and output registers live in `segment_feeder`.

## Test plan
- Reset, then push (start,1,1,5), (3,3,5), (5,1,5) → two `seg_val` pulses: (1,1,5)->(3,3,5) with `seg_num`=1, then (3,3,5)->(5,1,5) with `seg_num`=2. `skipped`=0.
- Push (start,0,0,2), (4,0,2), (4,0,3), (4,4,3) → segments (0,0,2)->(4,0,2) and (4,0,3)->(4,4,3). `skipped`=1.
- Push (start,2,2,1), (2,2,1), (6,2,1) → exactly one segment, (2,2,1)->(6,2,1). The zero-length point is dropped.
- Stream 62 non-degenerate same-z points with `pt_val` held high → 61 pulses with `seg_num` 1..61. `full`=1 after the last pulse. `pt_rdy` falls to 0 after 4 further points. No 62nd pulse.
- Hold `pt_val` high with a valid point during `flush` → the FIFO is empty the next cycle, count, `skipped` and `full` are 0, and no segment results from the flushed points.
- Assert `reset` low asynchronously the cycle a segment would emit → `seg_val`=0 immediately, all outputs 0, and the first segment after release has `seg_num`=1.
